// File: rtl/pb_operand_loader_if.sv
// Button/switch inputs and operand/status outputs of pb_operand_loader.
//   pb1..pb4 : raw pushbuttons (driven by master)
//   y        : raw 4-bit switch nibble (driven by master)
//   a, b     : 8-bit operands (driven by slave)
//   loaded   : sticky per-nibble load flags (driven by slave)
//   valid    : all four nibbles loaded (driven by slave)
//   upd      : one-cycle pulse after any nibble load (driven by slave)
interface pb_operand_loader_if;
    logic       pb1;
    logic       pb2;
    logic       pb3;
    logic       pb4;
    logic [3:0] y;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] loaded;
    logic       valid;
    logic       upd;

    modport master (
        output pb1, pb2, pb3, pb4, y,
        input  a, b, loaded, valid, upd
    );

    modport slave (
        input  pb1, pb2, pb3, pb4, y,
        output a, b, loaded, valid, upd
    );
endinterface

// File: rtl/pb_operand_loader.sv
// Synchronises and debounces four pushbuttons and a switch nibble, and on each
// debounced press captures the switch nibble into the mapped nibble of a or b.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of pb_operand_loader_if
//         pb1->a[3:0], pb2->a[7:4], pb3->b[3:0], pb4->b[7:4]
module pb_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    pb_operand_loader_if.slave bus
);

    localparam int unsigned NBTN = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  pb_s1;
    logic [NBTN-1:0]  pb_s2;
    logic [3:0]       y_s1;
    logic [3:0]       y_s2;
    logic [CNT_W-1:0] cnt [NBTN];
    logic [NBTN-1:0]  db;
    logic [NBTN-1:0]  db_d;
    logic [NBTN-1:0]  press;

    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [NBTN-1:0]  loaded_q;
    logic             valid_q;
    logic             upd_q;

    // Two-flop synchronisers for buttons and switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_s1 <= '0;
            pb_s2 <= '0;
            y_s1  <= '0;
            y_s2  <= '0;
        end else begin
            pb_s1 <= {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
            pb_s2 <= pb_s1;
            y_s1  <= bus.y;
            y_s2  <= y_s1;
        end
    end

    // Per-button debounce: level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db_d <= db;
            for (int i = 0; i < NBTN; i++) begin
                if (pb_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= pb_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level; releases never load
    assign press = db & ~db_d;

    // Nibble capture, sticky load flags and update pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            loaded_q <= '0;
            valid_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            if (press[0]) a_q[3:0] <= y_s2;
            if (press[1]) a_q[7:4] <= y_s2;
            if (press[2]) b_q[3:0] <= y_s2;
            if (press[3]) b_q[7:4] <= y_s2;
            loaded_q <= loaded_q | press;
            valid_q  <= &(loaded_q | press);
            upd_q    <= |press;
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.loaded = loaded_q;
    assign bus.valid  = valid_q;
    assign bus.upd    = upd_q;

endmodule

// File: tb/tb_pb_operand_loader.sv
// Directed and randomized bench for pb_operand_loader (DEBOUNCE_CYCLES=4).
// A reference model compares every output on every cycle; directed steps add
// fixed expected values for the key scenarios.
module tb_pb_operand_loader;

    localparam int DC = 4;
    localparam int HN = DC + 2;

    logic clk;
    logic rst;

    pb_operand_loader_if bus ();

    pb_operand_loader #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    // Reference model: raw samples per edge, newest at index 0
    logic [3:0] h_pb [HN];
    logic [3:0] h_y  [HN];
    logic [3:0] m_db;
    logic [3:0] m_pend;
    logic [3:0] m_loaded;
    logic [3:0] m_nib [4];
    logic       m_valid;
    logic       m_upd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < HN; i++) begin
            h_pb[i] = '0;
            h_y[i]  = '0;
        end
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        m_db = '0; m_pend = '0; m_loaded = '0; m_valid = 1'b0; m_upd = 1'b0;
    endtask

    // Level flips when the last DC synchronised samples all disagree with it;
    // a press loads on the edge after the level rises, using y seen 2 edges ago.
    task automatic model_edge();
        logic [3:0] new_pend;
        logic       all_diff;
        if (rst) begin
            model_clear();
            return;
        end
        for (int i = HN - 1; i > 0; i--) begin
            h_pb[i] = h_pb[i-1];
            h_y[i]  = h_y[i-1];
        end
        h_pb[0] = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
        h_y[0]  = bus.y;
        m_upd = |m_pend;
        for (int i = 0; i < 4; i++) if (m_pend[i]) m_nib[i] = h_y[2];
        m_loaded = m_loaded | m_pend;
        m_valid  = &m_loaded;
        new_pend = '0;
        for (int k = 0; k < 4; k++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DC + 1; j++) if (h_pb[j][k] == m_db[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_db[k] = ~m_db[k];
                if (m_db[k]) new_pend[k] = 1'b1;
            end
        end
        m_pend = new_pend;
    endtask

    task automatic drive_pb(input logic [3:0] m);
        bus.pb1 = m[0];
        bus.pb2 = m[1];
        bus.pb3 = m[2];
        bus.pb4 = m[3];
    endtask

    // One clock: update model at the edge, compare outputs 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle", 32'({bus.a, bus.b, bus.loaded, bus.valid, bus.upd}),
            32'({m_nib[1], m_nib[0], m_nib[3], m_nib[2], m_loaded, m_valid, m_upd}));
        if (bus.upd === 1'b1) upd_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        drive_pb(4'b0000);
        model_clear();
        #1;
        chk("rst_a", 32'(bus.a), 32'h00);
        chk("rst_b", 32'(bus.b), 32'h00);
        chk("rst_loaded", 32'(bus.loaded), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_upd", 32'(bus.upd), 32'h0);
        steps(3);
        #2;
        rst = 1'b0;
    endtask

    // Press mask with y, hold, release; reports edge index of first upd
    task automatic press(input logic [3:0] m, input logic [3:0] yv, input int hold,
                         input int relax, output int first);
        first = 0;
        bus.y = yv;
        drive_pb(m);
        for (int i = 1; i <= hold; i++) begin
            step();
            if (bus.upd === 1'b1 && first == 0) first = i;
        end
        drive_pb(4'b0000);
        steps(relax);
    endtask

    initial begin
        int first;
        rst = 1'b0;
        drive_pb(4'b0000);
        bus.y = 4'h0;
        model_clear();

        // Reset with no prior clock edge
        reset_pulse();
        steps(2);

        // Glitch of 3 cycles on pb2 is rejected
        upd_cnt = 0;
        drive_pb(4'b0010);
        bus.y = 4'h6;
        steps(3);
        drive_pb(4'b0000);
        steps(12);
        chk("glitch_a", 32'(bus.a), 32'h00);
        chk("glitch_loaded1", 32'(bus.loaded[1]), 32'h0);
        chk("glitch_upd", 32'(upd_cnt), 32'd0);

        // Full load of all four nibbles
        upd_cnt = 0;
        press(4'b0001, 4'h5, 10, 10, first); chk("lat_pb1", 32'(first), 32'd7);
        press(4'b0010, 4'hA, 10, 10, first); chk("lat_pb2", 32'(first), 32'd7);
        press(4'b0100, 4'h3, 10, 10, first); chk("lat_pb3", 32'(first), 32'd7);
        press(4'b1000, 4'hC, 10, 10, first); chk("lat_pb4", 32'(first), 32'd7);
        chk("full_a", 32'(bus.a), 32'hA5);
        chk("full_b", 32'(bus.b), 32'hC3);
        chk("full_loaded", 32'(bus.loaded), 32'hF);
        chk("full_valid", 32'(bus.valid), 32'h1);
        chk("full_upd_cycles", 32'(upd_cnt), 32'd4);

        // Bounce on pb3 then a solid hold
        upd_cnt = 0;
        bus.y = 4'h9;
        drive_pb(4'b0100); step();
        drive_pb(4'b0000); step();
        drive_pb(4'b0100); step();
        drive_pb(4'b0000); step();
        press(4'b0100, 4'h9, 10, 10, first);
        chk("bounce_b_lo", 32'(bus.b[3:0]), 32'h9);
        chk("bounce_upd", 32'(upd_cnt), 32'd1);

        // Simultaneous pb1 and pb4
        upd_cnt = 0;
        press(4'b1001, 4'hF, 10, 10, first);
        chk("simul_lat", 32'(first), 32'd7);
        chk("simul_a_lo", 32'(bus.a[3:0]), 32'hF);
        chk("simul_b_hi", 32'(bus.b[7:4]), 32'hF);
        chk("simul_upd", 32'(upd_cnt), 32'd1);

        // Long hold with y changing, then reload
        upd_cnt = 0;
        bus.y = 4'h1;
        drive_pb(4'b0001);
        steps(20);
        bus.y = 4'h2;
        steps(30);
        drive_pb(4'b0000);
        steps(10);
        chk("held_a_lo", 32'(bus.a[3:0]), 32'h1);
        chk("held_upd", 32'(upd_cnt), 32'd1);
        press(4'b0001, 4'h2, 10, 10, first);
        chk("reload_a_lo", 32'(bus.a[3:0]), 32'h2);
        chk("reload_loaded0", 32'(bus.loaded[0]), 32'h1);
        chk("reload_upd", 32'(upd_cnt), 32'd2);

        // Reset during a debounce discards the pending press
        bus.y = 4'h7;
        drive_pb(4'b0010);
        steps(3);
        reset_pulse();
        upd_cnt = 0;
        steps(20);
        chk("rstdb_loaded", 32'(bus.loaded), 32'h0);
        chk("rstdb_a", 32'(bus.a), 32'h00);
        chk("rstdb_upd", 32'(upd_cnt), 32'd0);

        // Randomized button/switch activity against the model
        for (int it = 0; it < 300; it++) begin
            logic [3:0] m;
            for (int k = 0; k < 4; k++) m[k] = ($urandom_range(0, 9) < 3);
            bus.y = 4'($urandom_range(0, 15));
            drive_pb(m);
            steps($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) begin
                drive_pb(4'b0000);
                steps($urandom_range(1, 8));
            end
        end
        drive_pb(4'b0000);
        steps(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
